// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame sequencer: FSM state encoding,
// header command bit position and frame counter width.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SRST,
        LOAD,
        DRAIN
    } seq_state_t;

    localparam int HDR_CMD_BIT    = 31;
    localparam int FRAME_CNT_BITS = 16;

endpackage

// File: rtl/frame_sequencer_beat_counter.sv
// Loadable down-counter that flags the final beat (count == 1); stops at zero
// so a stray decrement after the terminal beat cannot wrap.
module beat_counter
    import frame_seq_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign terminal = (count == W'(1));

endmodule

// File: rtl/frame_sequencer.sv
// Host-side frame controller: parses a length header, forwards LEN payload words
// to the datapath, waits for the result beats, and issues timed soft resets.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int MAX_WORDS    = 1024,
    parameter int RESULT_WORDS = 10,
    parameter int SRST_CYCLES  = 4,
    parameter int CNT_BITS     = $clog2(MAX_WORDS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               host_data,
    input  logic                      host_valid,
    output logic                      host_ready,
    output logic [31:0]               dp_data,
    output logic                      dp_valid,
    output logic                      dp_last,
    input  logic                      dp_ready,
    input  logic                      res_valid,
    input  logic                      res_ready,
    output logic                      soft_reset,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      len_err,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt
);

    localparam int RES_BITS  = $clog2(RESULT_WORDS + 1);
    localparam int SRST_BITS = $clog2(SRST_CYCLES + 1);

    seq_state_t          state;
    logic [RES_BITS-1:0] res_cnt;
    logic [RES_BITS-1:0] res_cnt_next;

    logic                host_fire;
    logic                res_fire;
    logic                hdr_cmd;
    logic [CNT_BITS-1:0] hdr_len;
    logic                hdr_ok;
    logic                rem_load;
    logic                rem_dec;
    logic                rem_term;
    logic                srst_load;
    logic                srst_dec;
    logic                srst_term;
    logic                res_count_en;
    logic                drain_done;

    // Ready/valid are pure state decodes so LOAD is a zero-latency pass-through.
    always_comb begin
        host_ready = 1'b0;
        dp_valid   = 1'b0;
        case (state)
            IDLE: host_ready = 1'b1;
            LOAD: begin
                host_ready = dp_ready;
                dp_valid   = host_valid;
            end
            default: ;
        endcase
    end

    assign dp_data = host_data;
    assign dp_last = (state == LOAD) && rem_term;
    assign busy    = (state != IDLE);

    assign host_fire = host_valid && host_ready;
    assign res_fire  = res_valid && res_ready;
    assign hdr_cmd   = host_data[HDR_CMD_BIT];
    assign hdr_len   = host_data[CNT_BITS-1:0];
    assign hdr_ok    = (hdr_len != '0) && (hdr_len <= CNT_BITS'(MAX_WORDS));

    assign rem_load  = (state == IDLE) && host_fire && !hdr_cmd && hdr_ok;
    assign rem_dec   = (state == LOAD) && host_fire;
    assign srst_load = (state == IDLE) && host_fire && hdr_cmd;
    assign srst_dec  = (state == SRST);

    // Results only count while a frame is in flight; the count saturates.
    assign res_count_en = ((state == LOAD) || (state == DRAIN)) && res_fire
                          && (res_cnt != RES_BITS'(RESULT_WORDS));

    always_comb begin
        res_cnt_next = res_cnt;
        if (rem_load) begin
            res_cnt_next = '0;
        end else if (res_count_en) begin
            res_cnt_next = res_cnt + RES_BITS'(1);
        end
    end

    assign drain_done = (state == DRAIN) && (res_cnt_next == RES_BITS'(RESULT_WORDS));

    beat_counter #(
        .W (CNT_BITS)
    ) u_remaining (
        .clock    (clock),
        .reset    (reset),
        .load     (rem_load),
        .load_val (hdr_len),
        .dec      (rem_dec),
        .terminal (rem_term)
    );

    beat_counter #(
        .W (SRST_BITS)
    ) u_srst (
        .clock    (clock),
        .reset    (reset),
        .load     (srst_load),
        .load_val (SRST_BITS'(SRST_CYCLES)),
        .dec      (srst_dec),
        .terminal (srst_term)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            res_cnt    <= '0;
            soft_reset <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            res_cnt    <= res_cnt_next;
            case (state)
                IDLE: begin
                    if (host_fire) begin
                        if (hdr_cmd) begin
                            state      <= SRST;
                            soft_reset <= 1'b1;
                        end else if (!hdr_ok) begin
                            len_err <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                SRST: begin
                    // Counter was loaded with SRST_CYCLES, so this state lasts that many cycles.
                    if (srst_term) begin
                        state      <= IDLE;
                        soft_reset <= 1'b0;
                    end
                end
                LOAD: begin
                    if (host_fire && rem_term) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + FRAME_CNT_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
